inst_rom_resp: RTL and testbench

//  Instruction-memory responder: the far end of the fetch interface driven by the PC stage.

---
 rtl/inst_rom_resp_if.sv | 24 ++
 rtl/inst_rom_resp.sv | 122 ++++++++++++
 tb/tb_inst_rom_resp.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_rom_resp_if.sv
// Fetch and loader bus between the PC stage (master) and the instruction-memory responder (slave).
interface inst_rom_resp_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              ce;
  logic [31:0]       addr;
  logic [31:0]       inst;
  logic              inst_valid;
  logic              stall_req;
  logic              addr_err;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;

  modport master (
    output ce, addr, ld_we, ld_addr, ld_data,
    input  inst, inst_valid, stall_req, addr_err
  );

  modport slave (
    input  ce, addr, ld_we, ld_addr, ld_data,
    output inst, inst_valid, stall_req, addr_err
  );
endinterface

// File: rtl/inst_rom_resp.sv
// Instruction-memory responder: word fetch after WAIT_CYC wait states with a one-cycle valid strobe,
// stall request while a fetch is outstanding, and a loader write port into the array.
module inst_rom_resp #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  inst_rom_resp_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam bit         ZERO_WAIT = (WAIT_CYC == 0);
  localparam logic [3:0] CNT_INIT  = 4'((WAIT_CYC == 0) ? 0 : WAIT_CYC - 1);
  localparam int unsigned DEPTH    = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              err_q, err_d;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_q;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_idx;

  logic [ADDR_W-1:0] req_idx;
  logic              req_aligned;
  logic              stall;
  logic              unused_addr_hi;

  // Upper address bits are deliberately dropped so addresses alias modulo the array depth.
  assign req_idx        = bus.addr[ADDR_W+1:2];
  assign req_aligned    = (bus.addr[1:0] == 2'b00);
  assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    rd_idx  = idx_q;
    stall   = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        // DONE shares the IDLE acceptance rules so back-to-back fetches need no bubble.
        state_d = IDLE;
        err_d   = 1'b0;
        if (bus.ce) begin
          if (!req_aligned) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            idx_d = req_idx;
            if (ZERO_WAIT) begin
              state_d = DONE;
              rd_en   = 1'b1;
              rd_idx  = req_idx;
            end else begin
              state_d = BUSY;
              cnt_d   = CNT_INIT;
              stall   = 1'b1;
            end
          end
        end
      end

      BUSY: begin
        stall = 1'b1;
        if (!bus.ce) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = DONE;
          rd_en   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Non-blocking write plus read in one block gives read-before-write on a shared index.
  always_ff @(posedge clk) begin
    if (bus.ld_we) begin
      mem[bus.ld_addr] <= bus.ld_data;
    end
    if (rd_en) begin
      rd_q <= mem[rd_idx];
    end
  end

  assign bus.inst_valid = (state_q == DONE);
  assign bus.addr_err   = (state_q == DONE) && err_q;
  assign bus.inst       = ((state_q == DONE) && !err_q) ? rd_q : '0;
  assign bus.stall_req  = rst && stall;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Drives three responders (WAIT_CYC 2, 0, 3) with shared directed stimulus and checks them
// against a transaction-level model plus hand-computed literal expectations.
module tb_inst_rom_resp;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  int total;
  int bad;

  inst_rom_resp_if #(.ADDR_W(10)) f2 ();
  inst_rom_resp_if #(.ADDR_W(10)) f0 ();
  inst_rom_resp_if #(.ADDR_W(10)) f3 ();

  assign f2.ce = ce;  assign f2.addr = addr;
  assign f2.ld_we = ld_we;  assign f2.ld_addr = ld_addr;  assign f2.ld_data = ld_data;
  assign f0.ce = ce;  assign f0.addr = addr;
  assign f0.ld_we = ld_we;  assign f0.ld_addr = ld_addr;  assign f0.ld_data = ld_data;
  assign f3.ce = ce;  assign f3.addr = addr;
  assign f3.ld_we = ld_we;  assign f3.ld_addr = ld_addr;  assign f3.ld_data = ld_data;

  inst_rom_resp #(.ADDR_W(10), .WAIT_CYC(2)) u_w2 (.clk(clk), .rst(rst), .bus(f2));
  inst_rom_resp #(.ADDR_W(10), .WAIT_CYC(0)) u_w0 (.clk(clk), .rst(rst), .bus(f0));
  inst_rom_resp #(.ADDR_W(10), .WAIT_CYC(3)) u_w3 (.clk(clk), .rst(rst), .bus(f3));

  // index 0: WAIT_CYC=2, 1: WAIT_CYC=0, 2: WAIT_CYC=3
  logic        o_v [3];
  logic [31:0] o_i [3];
  logic        o_e [3];
  logic        o_s [3];
  assign o_v[0] = f2.inst_valid;  assign o_i[0] = f2.inst;  assign o_e[0] = f2.addr_err;  assign o_s[0] = f2.stall_req;
  assign o_v[1] = f0.inst_valid;  assign o_i[1] = f0.inst;  assign o_e[1] = f0.addr_err;  assign o_s[1] = f0.stall_req;
  assign o_v[2] = f3.inst_valid;  assign o_i[2] = f3.inst;  assign o_e[2] = f3.addr_err;  assign o_s[2] = f3.stall_req;

  int unsigned WV [3] = '{2, 0, 3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: a fetch accepted at edge e completes at edge e+W unless ce is seen low before then.
  logic [31:0] mem_m [1024];
  bit          pend  [3];
  int unsigned due   [3];
  logic [9:0]  pidx  [3];
  bit          ev    [3];
  logic [31:0] ei    [3];
  bit          ee    [3];
  int unsigned ecnt;

  initial begin
    for (int i = 0; i < 1024; i++) mem_m[i] = '0;
    ecnt = 0;
    for (int k = 0; k < 3; k++) begin
      pend[k] = 0; ev[k] = 0; ei[k] = '0; ee[k] = 0; due[k] = 0; pidx[k] = '0;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        pend[k] = 0; ev[k] = 0; ei[k] = '0; ee[k] = 0;
      end
    end else begin
      ecnt++;
      for (int k = 0; k < 3; k++) begin
        ev[k] = 0; ei[k] = '0; ee[k] = 0;
        if (pend[k]) begin
          if (!ce) pend[k] = 0;
          else if (ecnt == due[k]) begin
            ev[k] = 1; ei[k] = mem_m[pidx[k]]; pend[k] = 0;
          end
        end else if (ce) begin
          if (addr[1:0] != 2'b00) begin
            ev[k] = 1; ee[k] = 1;
          end else if (WV[k] == 0) begin
            ev[k] = 1; ei[k] = mem_m[addr[11:2]];
          end else begin
            pend[k] = 1; due[k] = ecnt + WV[k]; pidx[k] = addr[11:2];
          end
        end
      end
      if (ld_we) mem_m[ld_addr] = ld_data;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_valid[%0d]", k), {31'd0, o_v[k]}, {31'd0, ev[k]});
      chk($sformatf("model_inst[%0d]", k), o_i[k], ev[k] ? ei[k] : 32'd0);
      if (ev[k]) chk($sformatf("model_err[%0d]", k), {31'd0, o_e[k]}, {31'd0, ee[k]});
      chk($sformatf("model_stall[%0d]", k), {31'd0, o_s[k]},
          {31'd0, rst && (pend[k] || (ce && addr[1:0] == 2'b00 && WV[k] != 0))});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic idle(input int n);
    ce = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; ce = 1'b0; addr = '0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    #2 rst = 1'b0;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      chk("reset_valid", {31'd0, o_v[k]}, 32'd0);
      chk("reset_inst", o_i[k], 32'd0);
      chk("reset_err", {31'd0, o_e[k]}, 32'd0);
      chk("reset_stall", {31'd0, o_s[k]}, 32'd0);
    end
    rst = 1'b1;
    tick();

    // 1: WAIT_CYC=2 basic fetch
    load(10'd0, 32'h3401_1100);
    ce = 1'b1; addr = 32'h0;
    #1 chk("t1_stall_c0", {31'd0, o_s[0]}, 32'd1);
    tick();
    chk("t1_stall_c1", {31'd0, o_s[0]}, 32'd1);
    chk("t1_valid_c1", {31'd0, o_v[0]}, 32'd0);
    tick();
    chk("t1_stall_c2", {31'd0, o_s[0]}, 32'd1);
    chk("t1_valid_c2", {31'd0, o_v[0]}, 32'd0);
    tick();
    chk("t1_valid_c3", {31'd0, o_v[0]}, 32'd1);
    chk("t1_inst_c3", o_i[0], 32'h3401_1100);
    chk("t1_err_c3", {31'd0, o_e[0]}, 32'd0);
    idle(5);

    // 2: WAIT_CYC=0 back-to-back
    load(10'd0, 32'h11); load(10'd1, 32'h22); load(10'd2, 32'h33);
    ce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = 32'(i * 4);
      #1 chk("t2_stall", {31'd0, o_s[1]}, 32'd0);
      tick();
      chk("t2_valid", {31'd0, o_v[1]}, 32'd1);
      chk("t2_inst", o_i[1], 32'h11 * 32'(i + 1));
    end
    idle(5);

    // 3: misaligned fetch
    ce = 1'b1; addr = 32'h2;
    #1 chk("t3_stall_w2", {31'd0, o_s[0]}, 32'd0);
    chk("t3_stall_w3", {31'd0, o_s[2]}, 32'd0);
    tick();
    ce = 1'b0;
    chk("t3_valid", {31'd0, o_v[0]}, 32'd1);
    chk("t3_err", {31'd0, o_e[0]}, 32'd1);
    chk("t3_inst", o_i[0], 32'd0);
    chk("t3_stall_done", {31'd0, o_s[0]}, 32'd0);
    idle(5);

    // 4: WAIT_CYC=3 abandoned fetch, then fetch of 0x4
    ce = 1'b1; addr = 32'h0;
    tick();
    ce = 1'b0;
    tick();
    chk("t4_abandon_valid", {31'd0, o_v[2]}, 32'd0);
    chk("t4_abandon_stall", {31'd0, o_s[2]}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_no_valid", {31'd0, o_v[2]}, 32'd0);
    end
    ce = 1'b1; addr = 32'h4;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_wait_valid", {31'd0, o_v[2]}, 32'd0);
      chk("t4_wait_stall", {31'd0, o_s[2]}, 32'd1);
    end
    tick();
    chk("t4_valid", {31'd0, o_v[2]}, 32'd1);
    chk("t4_inst", o_i[2], 32'h22);
    idle(5);

    // 5: asynchronous reset mid-BUSY
    ce = 1'b1; addr = 32'h8;
    tick();
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t5_rst_valid", {31'd0, o_v[k]}, 32'd0);
      chk("t5_rst_inst", o_i[k], 32'd0);
      chk("t5_rst_err", {31'd0, o_e[k]}, 32'd0);
      chk("t5_rst_stall", {31'd0, o_s[k]}, 32'd0);
    end
    ce = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      for (int k = 0; k < 3; k++) chk("t5_post_valid", {31'd0, o_v[k]}, 32'd0);
    end

    // 6: aliasing plus same-edge loader write (read-before-write)
    load(10'd0, 32'hDEAD_BEEF);
    ce = 1'b1; addr = 32'h1000;
    ld_we = 1'b1; ld_addr = 10'd0; ld_data = 32'h0;
    tick();
    ld_we = 1'b0;
    chk("t6_w0_valid", {31'd0, o_v[1]}, 32'd1);
    chk("t6_w0_inst", o_i[1], 32'hDEAD_BEEF);
    idle(5);
    ce = 1'b1; addr = 32'h0;
    tick();
    chk("t6_w0_after_write", o_i[1], 32'h0);
    idle(5);

    load(10'd0, 32'hDEAD_BEEF);
    ce = 1'b1; addr = 32'h1000;
    tick(); tick();
    ld_we = 1'b1; ld_addr = 10'd0; ld_data = 32'h0;
    tick();
    ld_we = 1'b0;
    chk("t6_w2_valid", {31'd0, o_v[0]}, 32'd1);
    chk("t6_w2_inst", o_i[0], 32'hDEAD_BEEF);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
